// File: rtl/pll_sup_pkg.sv
// Shared types and default timing for the PLL lock supervisor.
// Timing defaults are derived from the 50 MHz reference clock.
package pll_sup_pkg;

    localparam int unsigned REFCLK_HZ = 50_000_000;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    // 1 ms lock window; ~20 us settle window rounded up to a power of two.
    localparam int unsigned DEF_LOCK_TIMEOUT  = REFCLK_HZ / 1_000;
    localparam int unsigned DEF_SETTLE_CYCLES = 2 ** $clog2(REFCLK_HZ / 50_000);
    localparam int unsigned DEF_LOSS_FILTER   = 4;
    localparam int unsigned DEF_CNT_W         = 8;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } sup_state_e;

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Generic two-flop single-bit synchronizer with a selectable reset value,
// so it can also carry reset-style signals into other clock domains.
module bit_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: reset is synchronous here, so it is sampled inside the clocked branch only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier on the free-running reference clock;
// produces the downstream system reset plus relock debug status.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned LOSS_FILTER   = DEF_LOSS_FILTER,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clr_sticky,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             lock_ok,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_cnt
);

    localparam int unsigned TMR_MAX = max_of4(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, LOSS_FILTER);
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_FILTER - 1);

    sup_state_e       state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;
    logic             lock_lost_q, lock_lost_d;
    logic             pll_rst_q, sys_rst_q, lock_ok_q;
    logic             locked_s;
    logic             relock_evt;
    logic             loss_evt;

    bit_sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // One shared counter: state dwell time, or the unlock filter while in RUN.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + TMR_W'(1);
        relock_evt = 1'b0;
        loss_evt   = 1'b0;
        unique case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = PLL_RESET;
                    cnt_d      = '0;
                    relock_evt = 1'b1;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    state_d    = PLL_RESET;
                    cnt_d      = '0;
                    relock_evt = 1'b1;
                    loss_evt   = 1'b1;
                end
            end
            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase

        relock_cnt_d = relock_cnt_q;
        if (relock_evt && (relock_cnt_q != '1)) begin
            relock_cnt_d = relock_cnt_q + CNT_W'(1);
        end

        lock_lost_d = lock_lost_q;
        if (loss_evt) begin
            lock_lost_d = 1'b1;
        end else if (clr_sticky) begin
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= PLL_RESET;
            cnt_q        <= '0;
            relock_cnt_q <= '0;
            lock_lost_q  <= 1'b0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            lock_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            relock_cnt_q <= relock_cnt_d;
            lock_lost_q  <= lock_lost_d;
            // Outputs decode the next state so they switch on the transition edge.
            pll_rst_q    <= (state_d == PLL_RESET);
            sys_rst_q    <= (state_d != RUN);
            lock_ok_q    <= (state_d == RUN);
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign lock_ok    = lock_ok_q;
    assign lock_lost  = lock_lost_q;
    assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed vector table, hand-written
// corner sequences, then random lock behaviour against a history-based model.
module tb_pll_lock_supervisor;

    localparam int RST_C = 16;
    localparam int TO    = 300;
    localparam int SET_C = 1024;
    localparam int LF    = 4;
    localparam int CW    = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          refclk;
    logic          rst;
    logic          pll_locked;
    logic          clr_sticky;
    logic          pll_rst;
    logic          sys_rst;
    logic          lock_ok;
    logic          lock_lost;
    logic [CW-1:0] relock_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO),
        .SETTLE_CYCLES (SET_C),
        .LOSS_FILTER   (LF),
        .CNT_W         (CW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .clr_sticky (clr_sticky),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .lock_ok    (lock_ok),
        .lock_lost  (lock_lost),
        .relock_cnt (relock_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    // Reference model: phases with time-in-phase, a delayed view of pll_locked and
    // the running length of the current unlocked stretch.
    typedef enum int {M_RST, M_WAIT, M_SETTLE, M_RUN} mphase_e;
    mphase_e m_phase;
    int      m_age;
    int      m_low_run;
    int      m_relocks;
    bit      m_lost;
    bit      dly[$];

    task automatic model_edge(input logic r, input logic lk, input logic c);
        bit      ls;
        bit      loss;
        mphase_e nxt;
        if (r) begin
            m_phase = M_RST; m_age = 0; m_low_run = 0; m_relocks = 0; m_lost = 0;
            dly.delete(); dly.push_back(1'b0); dly.push_back(1'b0);
            return;
        end
        ls = dly.pop_front();
        dly.push_back(lk);
        m_low_run = ls ? 0 : m_low_run + 1;
        nxt  = m_phase;
        loss = 0;
        case (m_phase)
            M_RST:    if (m_age + 1 >= RST_C) nxt = M_WAIT;
            M_WAIT:   if (ls) nxt = M_SETTLE; else if (m_age + 1 >= TO) nxt = M_RST;
            M_SETTLE: if (!ls) nxt = M_WAIT; else if (m_age + 1 >= SET_C) nxt = M_RUN;
            M_RUN:    if (m_low_run >= LF) begin nxt = M_RST; loss = 1; end
            default:  nxt = M_RST;
        endcase
        if (nxt == M_RST && m_phase != M_RST && m_relocks < CNT_MAX) m_relocks++;
        if (loss) m_lost = 1;
        else if (c) m_lost = 0;
        m_age = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
    endtask

    function automatic logic [5:0] model_vec();
        return {m_phase == M_RST, m_phase != M_RUN, m_phase == M_RUN, m_lost, 2'(m_relocks)};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {pll_rst, sys_rst, lock_ok, lock_lost, relock_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic lk, input logic c);
        rst = r; pll_locked = lk; clr_sticky = c;
        @(posedge refclk);
        model_edge(r, lk, c);
        #1;
        cyc = r ? 0 : cyc + 1;
    endtask

    typedef struct {
        logic       r;
        logic       lk;
        logic       clr;
        int         n;
        logic [5:0] exp;   // {pll_rst, sys_rst, lock_ok, lock_lost, relock_cnt}
        string      name;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic lk, input logic clr, input int n,
                       input logic [5:0] exp, input string name);
        vec_t v;
        v.r = r; v.lk = lk; v.clr = clr; v.n = n; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0; clr_sticky = 1'b0;

        // ---------------- directed table ----------------
        add(1, 1, 0, 3,    6'b110000, "reset_state");
        add(0, 1, 0, 15,   6'b110000, "pll_rst_held_c15");
        add(0, 1, 0, 1,    6'b010000, "pll_rst_release_c16");
        add(0, 1, 0, 1024, 6'b010000, "settle_end_c1040");
        add(0, 1, 0, 1,    6'b001000, "run_entry_c1041");
        add(0, 0, 0, 3,    6'b001000, "glitch3_drive");
        add(0, 1, 0, 5,    6'b001000, "glitch3_ignored");
        add(0, 0, 0, 4,    6'b001000, "loss_drive");
        add(0, 1, 0, 1,    6'b001000, "loss_pre_edge");
        add(0, 1, 0, 1,    6'b110101, "loss_edge");
        add(0, 1, 0, 15,   6'b110101, "relock_pulse_c15");
        add(0, 1, 0, 1,    6'b010101, "relock_pulse_end");
        add(0, 1, 1, 1,    6'b010001, "clr_sticky");
        add(0, 1, 0, 1023, 6'b010001, "settle2_end");
        add(0, 1, 0, 1,    6'b001001, "run2_entry");
        add(0, 0, 0, 4,    6'b001001, "loss2_drive");
        add(0, 1, 0, 1,    6'b001001, "loss2_pre_edge");
        add(0, 1, 1, 1,    6'b110110, "clr_vs_loss");
        add(0, 1, 0, 1,    6'b110110, "lost_held");
        add(0, 1, 0, 1039, 6'b010110, "settle3_end");
        add(0, 1, 0, 1,    6'b001110, "run3_entry");
        add(1, 1, 0, 1,    6'b110000, "rst_in_run");

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].lk, tbl[i].clr);
            check(tbl[i].name, 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // ---------------- 1-cycle unlock in SETTLE at count 500 ----------------
        begin
            bit pulsed = 0;
            step(1, 1, 0); step(1, 1, 0);
            for (int c = 1; c <= 1545; c++) begin
                step(0, (c != 516), 0);
                if (c >= 516 && pll_rst) pulsed = 1;
                if (c == 518) check("settle_glitch_no_run", 32'({sys_rst, lock_ok}), 32'b10);
                if (c == 1542) check("settle_glitch_c1542", 32'({sys_rst, lock_ok}), 32'b10);
                if (c == 1543) check("settle_glitch_run_c1543", 32'({sys_rst, lock_ok}), 32'b01);
            end
            check("settle_glitch_no_pll_rst", 32'(pulsed), 32'd0);
        end

        // ---------------- pll_locked stuck low: timeout re-pulses, saturation ----------------
        step(1, 0, 0); step(1, 0, 0);
        for (int c = 1; c <= 5 * (RST_C + TO) + 20; c++) begin
            step(0, 0, 0);
            for (int k = 1; k <= 5; k++) begin
                int base = k * (RST_C + TO);
                if (c == base - 1) check("timeout_wait_end", 32'(pll_rst), 32'd0);
                if (c == base) check("timeout_pulse_start", 32'({pll_rst, relock_cnt}),
                                     32'({1'b1, 2'((k > CNT_MAX) ? CNT_MAX : k)}));
                if (c == base + RST_C - 1) check("timeout_pulse_last", 32'(pll_rst), 32'd1);
                if (c == base + RST_C) check("timeout_pulse_end", 32'(pll_rst), 32'd0);
            end
        end

        // ---------------- random lock behaviour vs model ----------------
        begin
            int  seg_len = 0;
            bit  seg_lk  = 1;
            step(1, 1, 0);
            for (int i = 0; i < 40000; i++) begin
                logic r, c;
                if (seg_len == 0) begin
                    seg_lk = ~seg_lk;
                    if (seg_lk) seg_len = $urandom_range(50, 3000);
                    else begin
                        case ($urandom_range(0, 9))
                            0, 1, 2, 3: seg_len = $urandom_range(1, 3);
                            4, 5, 6:    seg_len = $urandom_range(4, 8);
                            default:    seg_len = $urandom_range(9, 800);
                        endcase
                    end
                end
                seg_len--;
                r = ($urandom_range(0, 4999) == 0);
                c = ($urandom_range(0, 99) < 3);
                step(r, seg_lk, c);
                check("random_vs_model", 32'(dut_vec()), 32'(model_vec()));
                if (n_errors > 50) break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
